// File: rtl/image_frame_streamer.sv
// rtl/image_frame_streamer.sv - snapshots the 32x32 VGA bitmap at vsync and streams it row by row.
// Optional bounding-box tracking is enabled with IMG_BBOX_EN.
module image_frame_streamer #(
    parameter int IMG_DIM = 32
) (
    input  logic                       clkVga,
    input  logic                       iRstN,
    input  logic                       iVs,
    input  logic [IMG_DIM*IMG_DIM-1:0] iImage,
    input  logic                       iStart,
    output logic                       oBusy,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [IMG_DIM-1:0]         oData,
    output logic [4:0]                 oRow,
    output logic                       oLast,
    output logic                       oDone,
`ifdef IMG_BBOX_EN
    output logic [4:0]                 oXMin,
    output logic [4:0]                 oXMax,
    output logic [4:0]                 oYMin,
    output logic [4:0]                 oYMax,
    output logic                       oEmpty,
`endif
    output logic [10:0]                oPixCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [IMG_DIM*IMG_DIM-1:0] snap_q;
    logic [4:0]                 row_q;
    logic [10:0]                count_q;
    logic [10:0]                pix_q;
    logic                       vs_q1, vs_q2;
    logic                       fall;
    logic                       capture;
    logic                       hs;
    logic [IMG_DIM-1:0]         row_data;
    logic [5:0]                 row_pop;

    assign fall = vs_q2 & ~vs_q1;

    // Transposed read: word bit x is pixel (x, row_q).
    always_comb begin
        row_data = '0;
        row_pop  = '0;
        for (int x = 0; x < IMG_DIM; x++) begin
            row_data[x] = snap_q[{5'(x), row_q}];
            row_pop     = row_pop + 6'(snap_q[{5'(x), row_q}]);
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (fall) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                hs = iReady;
                if (iReady && (row_q == 5'd31)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            count_q <= '0;
            pix_q   <= '0;
            vs_q1   <= 1'b1;
            vs_q2   <= 1'b1;
        end else begin
            vs_q1   <= iVs;
            vs_q2   <= vs_q1;
            state_q <= state_d;
            if (capture) begin
                snap_q  <= iImage;
                row_q   <= '0;
                count_q <= '0;
            end else if (hs) begin
                row_q   <= row_q + 5'd1;
                count_q <= count_q + {5'd0, row_pop};
            end
            if (state_q == DONE) pix_q <= count_q;
        end
    end

    assign oBusy     = (state_q != IDLE);
    assign oValid    = (state_q == SEND);
    assign oData     = row_data;
    assign oRow      = row_q;
    assign oLast     = (state_q == SEND) && (row_q == 5'd31);
    assign oDone     = (state_q == DONE);
    assign oPixCount = pix_q;

`ifdef IMG_BBOX_EN
    logic       bb_any;
    logic [4:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [4:0] lo_x, hi_x;
    logic       row_any;

    always_comb begin
        lo_x    = '0;
        hi_x    = '0;
        row_any = |row_data;
        for (int i = IMG_DIM - 1; i >= 0; i--) begin
            if (row_data[i]) lo_x = 5'(i);
        end
        for (int i = 0; i < IMG_DIM; i++) begin
            if (row_data[i]) hi_x = 5'(i);
        end
    end

    // Rows arrive in ascending order, so the latest set row is always the y maximum.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            bb_any  <= 1'b0;
            bb_xmin <= '0;
            bb_xmax <= '0;
            bb_ymin <= '0;
            bb_ymax <= '0;
            oXMin   <= '0;
            oXMax   <= '0;
            oYMin   <= '0;
            oYMax   <= '0;
            oEmpty  <= 1'b1;
        end else begin
            if (capture) begin
                bb_any  <= 1'b0;
                bb_xmin <= '0;
                bb_xmax <= '0;
                bb_ymin <= '0;
                bb_ymax <= '0;
            end else if (hs && row_any) begin
                bb_any  <= 1'b1;
                bb_ymax <= row_q;
                if (!bb_any) begin
                    bb_xmin <= lo_x;
                    bb_xmax <= hi_x;
                    bb_ymin <= row_q;
                end else begin
                    if (lo_x < bb_xmin) bb_xmin <= lo_x;
                    if (hi_x > bb_xmax) bb_xmax <= hi_x;
                end
            end
            if (state_q == DONE) begin
                oXMin  <= bb_xmin;
                oXMax  <= bb_xmax;
                oYMin  <= bb_ymin;
                oYMax  <= bb_ymax;
                oEmpty <= ~bb_any;
            end
        end
    end
`endif

endmodule

// File: tb/tb_image_frame_streamer.sv
// tb/tb_image_frame_streamer.sv - scoreboard bench for image_frame_streamer.
// Expected rows and frame results are pushed at stimulus time and popped by a monitor.
module tb_image_frame_streamer;

    logic          clkVga = 1'b0;
    logic          iRstN  = 1'b0;
    logic          iVs    = 1'b1;
    logic [1023:0] iImage = '0;
    logic          iStart = 1'b0;
    logic          iReady = 1'b0;
    logic          oBusy, oValid, oLast, oDone;
    logic [31:0]   oData;
    logic [4:0]    oRow;
    logic [10:0]   oPixCount;
`ifdef IMG_BBOX_EN
    logic [4:0]    oXMin, oXMax, oYMin, oYMax;
    logic          oEmpty;
`endif

    image_frame_streamer #(.IMG_DIM(32)) dut (
        .clkVga(clkVga), .iRstN(iRstN), .iVs(iVs), .iImage(iImage), .iStart(iStart),
        .oBusy(oBusy), .oValid(oValid), .iReady(iReady), .oData(oData), .oRow(oRow),
        .oLast(oLast), .oDone(oDone),
`ifdef IMG_BBOX_EN
        .oXMin(oXMin), .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax), .oEmpty(oEmpty),
`endif
        .oPixCount(oPixCount)
    );

    always #12.5 clkVga = ~clkVga;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  row;
        logic        last;
    } row_t;

    typedef struct {
        logic [10:0] cnt;
        logic [4:0]  xmin, xmax, ymin, ymax;
        logic        empty;
    } done_t;

    row_t  exp_rows[$];
    done_t exp_done[$];
    int    checks = 0;
    int    errors = 0;
    int    rmode  = 0;
    int    rcnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel (x,y) lives at x*32+y; row y is read across all x.
    task automatic push_frame(input logic [1023:0] img);
        done_t d;
        row_t  r;
        d.cnt = 0; d.xmin = 31; d.xmax = 0; d.ymin = 31; d.ymax = 0; d.empty = 1;
        for (int y = 0; y < 32; y++) begin
            r.data = 0;
            for (int x = 0; x < 32; x++) begin
                if (img[x*32+y]) begin
                    r.data[x] = 1'b1;
                    d.cnt++;
                    d.empty = 0;
                    if (x < int'(d.xmin)) d.xmin = 5'(x);
                    if (x > int'(d.xmax)) d.xmax = 5'(x);
                    if (y < int'(d.ymin)) d.ymin = 5'(y);
                    if (y > int'(d.ymax)) d.ymax = 5'(y);
                end
            end
            r.row  = 5'(y);
            r.last = (y == 31);
            exp_rows.push_back(r);
        end
        if (d.empty) begin
            d.xmin = 0; d.xmax = 0; d.ymin = 0; d.ymax = 0;
        end
        exp_done.push_back(d);
    endtask

    // iReady: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    always @(posedge clkVga) begin
        #1;
        case (rmode)
            0: iReady = 1'b1;
            1: begin
                iReady = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                rcnt++;
            end
            default: iReady = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pop and compare on every handshake and every oDone.
    logic        held = 1'b0;
    logic [31:0] h_data;
    logic [4:0]  h_row;
    logic        h_last;
    always @(negedge clkVga) begin
        row_t  r;
        done_t d;
        if (oValid) begin
            if (held) begin
                chk("stall_data", oData, h_data);
                chk("stall_row", 32'(oRow), 32'(h_row));
                chk("stall_last", 32'(oLast), 32'(h_last));
            end
            if (iReady) begin
                held = 1'b0;
                if (exp_rows.size() == 0) begin
                    chk("unexpected_row", 32'(oRow), 32'hFFFF_FFFF);
                end else begin
                    r = exp_rows.pop_front();
                    chk("row_data", oData, r.data);
                    chk("row_index", 32'(oRow), 32'(r.row));
                    chk("row_last", 32'(oLast), 32'(r.last));
                end
            end else begin
                held   = 1'b1;
                h_data = oData;
                h_row  = oRow;
                h_last = oLast;
            end
        end else begin
            held = 1'b0;
        end
        if (oDone) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 32'(oDone), 32'd0);
            end else begin
                d = exp_done.pop_front();
                @(posedge clkVga);
                #1;
                chk("pix_count", 32'(oPixCount), 32'(d.cnt));
`ifdef IMG_BBOX_EN
                chk("bb_xmin", 32'(oXMin), 32'(d.xmin));
                chk("bb_xmax", 32'(oXMax), 32'(d.xmax));
                chk("bb_ymin", 32'(oYMin), 32'(d.ymin));
                chk("bb_ymax", 32'(oYMax), 32'(d.ymax));
                chk("bb_empty", 32'(oEmpty), 32'(d.empty));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clkVga);
        #1;
    endtask

    task automatic vs_pulse();
        iVs = 1'b0;
        cyc(4);
        iVs = 1'b1;
        cyc(2);
    endtask

    task automatic start_frame(input logic [1023:0] img);
        iImage = img;
        push_frame(img);
        iStart = 1'b1;
        cyc(1);
        iStart = 1'b0;
        cyc(2);
        vs_pulse();
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 200; k++) begin
            if (oValid) break;
            cyc(1);
        end
        chk("valid_timeout", 32'(k < 200), 32'd1);
    endtask

    task automatic finish_frame();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clkVga);
            if (oDone) break;
        end
        chk("done_timeout", 32'(k < 3000), 32'd1);
        cyc(2);
        chk("busy_after_done", 32'(oBusy), 32'd0);
    endtask

    function automatic logic [1023:0] rand_img(input int sparse);
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) begin
            v[i*32 +: 32] = sparse ? ($urandom & $urandom & $urandom) : $urandom;
        end
        return v;
    endfunction

    initial begin
        logic [1023:0] img;
        int k;
        #30000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [1023:0] img;
        int k;
        cyc(3);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_row", 32'(oRow), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_pix", 32'(oPixCount), 32'd0);
`ifdef IMG_BBOX_EN
        chk("rst_empty", 32'(oEmpty), 32'd1);
`endif
        iRstN = 1'b1;
        cyc(2);

        // Abort a stream at row 12 with an asynchronous reset.
        rmode = 0;
        start_frame(rand_img(0));
        for (k = 0; k < 200; k++) begin
            @(negedge clkVga);
            if (oValid && oRow == 5'd12) break;
        end
        chk("reach_row12", 32'(k < 200), 32'd1);
        #2;
        iRstN = 1'b0;
        #2;
        exp_rows.delete();
        exp_done.delete();
        chk("abort_valid", 32'(oValid), 32'd0);
        chk("abort_row", 32'(oRow), 32'd0);
        chk("abort_busy", 32'(oBusy), 32'd0);
        cyc(1);
        chk("abort_valid_next", 32'(oValid), 32'd0);
        chk("abort_pix", 32'(oPixCount), 32'd0);
        iRstN = 1'b1;
        cyc(50);

        // All zeros, then diagonal, then a single pixel with a fixed stall pattern.
        start_frame('0);
        finish_frame();
        img = '0;
        for (int i = 0; i < 32; i++) img[i*32+i] = 1'b1;
        start_frame(img);
        finish_frame();
        img = '0;
        img[5*32+20] = 1'b1;
        rmode = 1;
        rcnt  = 0;
        start_frame(img);
        finish_frame();

        // Image overwritten right after the snapshot must not reach the stream.
        rmode = 0;
        img = rand_img(0);
        start_frame(img);
        wait_valid();
        iImage = '1;
        finish_frame();
        start_frame('1);
        finish_frame();

        // iStart coincident with the falling edge: that edge is ignored.
        img = rand_img(1);
        iImage = img;
        iVs = 1'b0;
        cyc(1);
        iStart = 1'b1;
        cyc(1);
        iStart = 1'b0;
        cyc(3);
        iVs = 1'b1;
        cyc(2);
        chk("wait_vs_busy", 32'(oBusy), 32'd1);
        chk("wait_vs_novalid", 32'(oValid), 32'd0);
        img = rand_img(0);
        push_frame(img);
        iImage = img;
        cyc(5);
        vs_pulse();
        wait_valid();
        cyc(3);
        iStart = 1'b1;
        cyc(1);
        iStart = 1'b0;
        cyc(4);
        iStart = 1'b1;
        cyc(1);
        iStart = 1'b0;
        finish_frame();

        // Randomized frames with random backpressure.
        rmode = 2;
        for (int f = 0; f < 4; f++) begin
            start_frame(rand_img(f % 2));
            finish_frame();
        end

        cyc(5);
        chk("rows_drained", 32'(exp_rows.size()), 32'd0);
        chk("done_drained", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
